// File: rtl/bcd_conv_arbiter_pkg.sv
// Shared definitions for the BCD converter arbiter: FSM states, digit width, defaults.
package bcd_conv_arbiter_pkg;

    localparam int unsigned DIGIT_W            = 4;
    localparam int unsigned DEF_NUM_REQ        = 4;
    localparam int unsigned DEF_BIN_W          = 14;
    localparam int unsigned DEF_BCD_DIGITS     = 4;
    localparam int unsigned DEF_ID_W           = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Largest value representable with the given number of BCD digits (10^digits - 1).
    function automatic int unsigned bcd_max(input int unsigned digits);
        int unsigned m;
        m = 1;
        for (int unsigned i = 0; i < digits; i++) begin
            m = m * 10;
        end
        return m - 1;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: one operand bit per cycle, BIN_W cycles per operand.
module bin2bcd_seq
    import bcd_conv_arbiter_pkg::*;
#(
    parameter int unsigned BIN_W      = DEF_BIN_W,
    parameter int unsigned BCD_DIGITS = DEF_BCD_DIGITS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [BIN_W-1:0]              bin_in,
    output logic                          busy,
    output logic                          done,
    output logic [DIGIT_W*BCD_DIGITS-1:0] bcd_out
);

    localparam int unsigned BCD_W = DIGIT_W * BCD_DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    logic [BIN_W-1:0] shreg;
    logic [CNT_W-1:0] cnt;
    logic [BCD_W-1:0] adj_c;

    // Add-3 correction of every digit that is 5 or more before the next shift.
    always_comb begin
        adj_c = bcd_out;
        for (int d = 0; d < int'(BCD_DIGITS); d++) begin
            if (bcd_out[DIGIT_W*d +: DIGIT_W] >= 4'd5) begin
                adj_c[DIGIT_W*d +: DIGIT_W] = bcd_out[DIGIT_W*d +: DIGIT_W] + 4'd3;
            end
        end
    end

    // Load on start, then shift the corrected digits and the operand left once per cycle.
    // done is high during the cycle in which the final shift takes place.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg   <= '0;
            cnt     <= '0;
            bcd_out <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else if (start) begin
            shreg   <= bin_in;
            cnt     <= '0;
            bcd_out <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
        end else if (busy) begin
            bcd_out <= {adj_c[BCD_W-2:0], shreg[BIN_W-1]};
            shreg   <= {shreg[BIN_W-2:0], 1'b0};
            cnt     <= cnt + CNT_W'(1);
            done    <= (cnt == CNT_W'(BIN_W - 2));
            if (cnt == CNT_W'(BIN_W - 1)) begin
                busy <= 1'b0;
            end
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one sequential binary-to-BCD converter among NUM_REQ clients.
module bcd_conv_arbiter
    import bcd_conv_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
    parameter int unsigned BIN_W      = DEF_BIN_W,
    parameter int unsigned BCD_DIGITS = DEF_BCD_DIGITS,
    parameter int unsigned ID_W       = DEF_ID_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*BIN_W-1:0]      req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DIGIT_W*BCD_DIGITS-1:0] rsp_bcd,
    output logic [ID_W-1:0]               rsp_id,
    output logic                          rsp_ovf,
    output logic                          busy
);

    localparam int unsigned BCD_W   = DIGIT_W * BCD_DIGITS;
    localparam int unsigned BCD_MAX = bcd_max(BCD_DIGITS);
    localparam logic [BCD_W-1:0] ALL_NINES = {BCD_DIGITS{4'h9}};

    state_t               state;
    logic [ID_W-1:0]      rr_ptr;
    logic [ID_W-1:0]      id_q;
    logic                 ovf_q;

    int unsigned          idx_c;
    logic                 win_found_c;
    logic [ID_W-1:0]      win_id_c;
    logic [NUM_REQ-1:0]   win_onehot_c;
    logic [BIN_W-1:0]     win_data_c;
    logic                 hs_c;

    logic                 conv_busy;
    logic                 conv_done;
    logic [BCD_W-1:0]     conv_bcd;

    // Round-robin search: first valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        idx_c        = 0;
        win_found_c  = 1'b0;
        win_id_c     = '0;
        win_onehot_c = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx_c = (32'(rr_ptr) + k) % NUM_REQ;
            if (!win_found_c && ((req_valid & (NUM_REQ'(1) << idx_c)) != '0)) begin
                win_found_c  = 1'b1;
                win_id_c     = ID_W'(idx_c);
                win_onehot_c = NUM_REQ'(1) << idx_c;
            end
        end
    end

    // Grant is only offered while idle; the winner's operand is steered to the converter.
    always_comb begin
        req_ready  = (state == ST_IDLE) ? win_onehot_c : '0;
        win_data_c = BIN_W'(req_data >> (32'(win_id_c) * BIN_W));
        hs_c       = (state == ST_IDLE) && win_found_c;
    end

    bin2bcd_seq #(
        .BIN_W      (BIN_W),
        .BCD_DIGITS (BCD_DIGITS)
    ) u_conv (
        .clk     (clk),
        .rst     (rst),
        .start   (hs_c),
        .bin_in  (win_data_c),
        .busy    (conv_busy),
        .done    (conv_done),
        .bcd_out (conv_bcd)
    );

    // Control FSM: grant and latch in IDLE, wait out the conversion, then present the
    // result one cycle into RESP and hold it until the consumer accepts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            id_q      <= '0;
            ovf_q     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_bcd   <= '0;
            rsp_id    <= '0;
            rsp_ovf   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (hs_c) begin
                        state  <= ST_CONV;
                        busy   <= 1'b1;
                        id_q   <= win_id_c;
                        ovf_q  <= (32'(win_data_c) > BCD_MAX);
                        rr_ptr <= ID_W'((32'(win_id_c) + 32'd1) % NUM_REQ);
                    end
                end
                ST_CONV: begin
                    if (conv_done) begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_valid) begin
                        if (rsp_ready) begin
                            state     <= ST_IDLE;
                            busy      <= 1'b0;
                            rsp_valid <= 1'b0;
                        end
                    end else if (!conv_busy) begin
                        rsp_valid <= 1'b1;
                        rsp_bcd   <= ovf_q ? ALL_NINES : conv_bcd;
                        rsp_id    <= id_q;
                        rsp_ovf   <= ovf_q;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Self-checking bench for bcd_conv_arbiter: per-cycle comparison against a behavioural model
// plus directed scenarios with literal expectations.
module tb_bcd_conv_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int BIN_W      = 14;
    localparam int BCD_DIGITS = 4;
    localparam int ID_W       = 2;
    localparam int LAT        = BIN_W + 1;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [NUM_REQ-1:0]      req_valid = '0;
    logic [NUM_REQ*BIN_W-1:0] req_data = '0;
    logic [NUM_REQ-1:0]      req_ready;
    logic                    rsp_valid;
    logic                    rsp_ready = 1'b0;
    logic [4*BCD_DIGITS-1:0] rsp_bcd;
    logic [ID_W-1:0]         rsp_id;
    logic                    rsp_ovf;
    logic                    busy;

    bcd_conv_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .BIN_W      (BIN_W),
        .BCD_DIGITS (BCD_DIGITS),
        .ID_W       (ID_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_bcd   (rsp_bcd),
        .rsp_id    (rsp_id),
        .rsp_ovf   (rsp_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Decimal digits of v, or all nines when v does not fit in four digits.
    function automatic logic [15:0] ref_bcd(input int v);
        logic [15:0] r;
        int x;
        r = '0;
        if (v > 9999) return 16'h9999;
        x = v;
        for (int d = 0; d < 4; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int ref_winner(input logic [NUM_REQ-1:0] v, input int rr);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (v[(rr + k) % NUM_REQ]) return (rr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    // Model state: idle flag, cycles since grant, served operand/id, rotation pointer.
    bit m_armed = 1'b0;
    bit m_idle  = 1'b1;
    bit m_fresh = 1'b1;
    int m_age   = 0;
    int m_rr    = 0;
    int m_id    = 0;
    int m_op    = 0;
    int m_win;

    always_comb m_win = ref_winner(req_valid, m_rr);

    always @(posedge clk) begin
        if (rst) begin
            m_armed <= 1'b1;
            m_idle  <= 1'b1;
            m_fresh <= 1'b1;
            m_age   <= 0;
            m_rr    <= 0;
        end else if (m_idle) begin
            if (m_win >= 0) begin
                m_idle <= 1'b0;
                m_age  <= 0;
                m_id   <= m_win;
                m_op   <= int'(req_data[m_win*BIN_W +: BIN_W]);
                m_rr   <= (m_win + 1) % NUM_REQ;
            end
        end else if (m_age >= LAT && rsp_ready) begin
            m_idle <= 1'b1;
        end else begin
            m_age <= m_age + 1;
            if (m_age + 1 == LAT) m_fresh <= 1'b0;
        end
    end

    int          rq_id[$];
    logic [15:0] rq_bcd[$];
    bit          rq_ovf[$];

    // Per-cycle comparison against the model, and capture of accepted responses.
    always @(negedge clk) begin
        if (m_armed) begin
            check("busy", busy, !m_idle);
            check("rsp_valid", rsp_valid, (!m_idle && m_age >= LAT));
            check("req_ready", req_ready, (m_idle && m_win >= 0) ? (32'd1 << m_win) : 32'd0);
            if (m_fresh || (!m_idle && m_age >= LAT)) begin
                check("rsp_bcd", rsp_bcd, m_fresh ? 32'd0 : 32'(ref_bcd(m_op)));
                check("rsp_id", rsp_id, m_fresh ? 32'd0 : m_id);
                check("rsp_ovf", rsp_ovf, m_fresh ? 32'd0 : 32'(m_op > 9999));
            end
            if (!rst && rsp_valid && rsp_ready) begin
                rq_id.push_back(int'(rsp_id));
                rq_bcd.push_back(rsp_bcd);
                rq_ovf.push_back(rsp_ovf);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) step();
        rst = 1'b0;
    endtask

    task automatic set_op(input int i, input int v);
        req_data[i*BIN_W +: BIN_W] = BIN_W'(v);
    endtask

    task automatic clear_q();
        rq_id.delete();
        rq_bcd.delete();
        rq_ovf.delete();
    endtask

    task automatic wait_rsp(input int n, input int budget);
        int c;
        c = 0;
        while (rq_id.size() < n && c < budget) begin
            step();
            c++;
        end
        if (rq_id.size() < n) check("rsp_timeout", rq_id.size(), n);
    endtask

    task automatic drain();
        int c;
        c = 0;
        rsp_ready = 1'b1;
        while ((busy || rsp_valid) && c < 80) begin
            step();
            c++;
        end
        if (busy) check("drain_timeout", busy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int n;
        int v;
        int          exp_ids[5]  = '{0, 1, 2, 3, 0};
        logic [15:0] exp_bcds[5] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0011};
        int          ops4[3]     = '{10000, 16383, 42};
        logic [15:0] bcd4[3]     = '{16'h9999, 16'h9999, 16'h0042};
        int          ovf4[3]     = '{1, 1, 0};

        // Reset state and single request latency
        rsp_ready = 1'b1;
        do_reset(2);
        check("reset_busy", busy, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_bcd", rsp_bcd, 0);
        check("reset_rsp_id", rsp_id, 0);
        check("reset_rsp_ovf", rsp_ovf, 0);
        clear_q();
        set_op(0, 1234);
        req_valid = 4'b0001;
        #1;
        check("s1_req_ready", req_ready, 4'b0001);
        step();
        req_valid = '0;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            step();
            lat++;
        end
        check("s1_latency", lat, 15);
        check("s1_bcd", rsp_bcd, 16'h1234);
        check("s1_id", rsp_id, 0);
        check("s1_ovf", rsp_ovf, 0);
        drain();

        // Sweep of operands from requester 2
        clear_q();
        req_valid = 4'b0100;
        for (int i = 0; i <= 101; i++) begin
            v = (i <= 100) ? i * 99 : 9999;
            set_op(2, v);
            n = rq_id.size();
            wait_rsp(n + 1, 60);
            if (rq_id.size() > n) begin
                check("s2_id", rq_id[n], 2);
                check("s2_bcd", rq_bcd[n], ref_bcd(v));
                check("s2_ovf", rq_ovf[n], 0);
            end
        end
        req_valid = '0;
        drain();

        // Contention: all four requesters continuously valid
        do_reset(1);
        clear_q();
        set_op(0, 11);
        set_op(1, 22);
        set_op(2, 33);
        set_op(3, 44);
        req_valid = 4'b1111;
        wait_rsp(5, 120);
        req_valid = '0;
        if (rq_id.size() >= 5) begin
            for (int i = 0; i < 5; i++) begin
                check("s3_id", rq_id[i], exp_ids[i]);
                check("s3_bcd", rq_bcd[i], exp_bcds[i]);
            end
        end
        drain();

        // Overflow operands followed by an in-range one
        do_reset(1);
        clear_q();
        req_valid = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            set_op(0, ops4[i]);
            wait_rsp(i + 1, 60);
            if (rq_id.size() > i) begin
                check("s4_bcd", rq_bcd[i], bcd4[i]);
                check("s4_ovf", rq_ovf[i], ovf4[i]);
            end
        end
        req_valid = '0;
        drain();

        // Backpressure with requester 1 pending
        do_reset(1);
        rsp_ready = 1'b0;
        set_op(0, 500);
        set_op(1, 600);
        req_valid = 4'b0011;
        step();
        req_valid = 4'b0010;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            step();
            lat++;
        end
        for (int i = 0; i < 20; i++) begin
            check("s5_valid_held", rsp_valid, 1);
            check("s5_bcd_held", rsp_bcd, 16'h0500);
            check("s5_id_held", rsp_id, 0);
            check("s5_no_grant", req_ready, 4'b0000);
            step();
        end
        rsp_ready = 1'b1;
        step();
        check("s5_grant_after", req_ready, 4'b0010);
        step();
        req_valid = '0;
        drain();

        // Reset in the middle of a conversion
        do_reset(1);
        set_op(0, 1234);
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        repeat (5) step();
        rst = 1'b1;
        step();
        check("s6_busy", busy, 0);
        check("s6_rsp_valid", rsp_valid, 0);
        check("s6_rsp_bcd", rsp_bcd, 0);
        rst = 1'b0;
        clear_q();
        set_op(0, 5);
        set_op(1, 9);
        req_valid = 4'b0011;
        #1;
        check("s6_rr_ptr_zero", req_ready, 4'b0001);
        step();
        req_valid = '0;
        wait_rsp(1, 40);
        if (rq_id.size() >= 1) check("s6_bcd", rq_bcd[0], 16'h0005);
        drain();

        // Randomized traffic with occasional resets
        do_reset(1);
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) req_valid = NUM_REQ'($urandom);
            for (int i = 0; i < NUM_REQ; i++) begin
                if ($urandom_range(0, 4) == 0) begin
                    case ($urandom_range(0, 5))
                        0: set_op(i, 9999);
                        1: set_op(i, 10000);
                        2: set_op(i, 0);
                        3: set_op(i, int'($urandom_range(0, 9999)));
                        default: set_op(i, int'($urandom_range(0, 16383)));
                    endcase
                end
            end
            rsp_ready = ($urandom_range(0, 9) < 7);
            rst = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 1'b0;
        req_valid = '0;
        drain();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
